da_fir_sequencer: RTL

Control and output-combine stage for the bit-serial distributed-arithmetic FIR. It accepts parallel input samples over a valid/ready handshake and drives the subfilter chain's shared `en`, `x_we`, `ts` and parallel `x`. On the sign-bit cycle it sums the `y` outputs of all subfilters and presents one registered filter result per sample over a valid/ready handshake. It sits upstream of the first subfilter for control and data, and downstream of every subfilter for the result.

---
 rtl/da_fir_sequencer_pkg.sv | 14 +
 rtl/da_fir_sequencer_if.sv | 32 +++
 rtl/da_fir_sequencer_adder_tree.sv | 25 ++
 rtl/da_fir_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/da_fir_sequencer_pkg.sv
// Shared state encoding and result-width helper for the distributed-arithmetic FIR sequencer.
package da_fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } seq_state_t;

  function automatic int sum_width(input int word_width, input int n);
    return word_width + $clog2(n);
  endfunction

endpackage

// File: rtl/da_fir_sequencer_if.sv
// Sample/result handshakes plus subfilter-chain control and data for the DA FIR sequencer.
interface da_fir_sequencer_if #(
  parameter int WORD_WIDTH     = 16,
  parameter int NUM_SUBFILTERS = 2
);
  import da_fir_pkg::*;

  localparam int SUM_WIDTH = sum_width(WORD_WIDTH, NUM_SUBFILTERS);

  logic                                 in_valid;
  logic                                 in_ready;
  logic [WORD_WIDTH-1:0]                in_data;
  logic                                 en;
  logic                                 x_we;
  logic [WORD_WIDTH-1:0]                x;
  logic                                 ts;
  logic [NUM_SUBFILTERS*WORD_WIDTH-1:0] y_sub;
  logic                                 out_valid;
  logic                                 out_ready;
  logic signed [SUM_WIDTH-1:0]          out_data;

  modport master (
    input  in_valid, in_data, y_sub, out_ready,
    output in_ready, en, x_we, x, ts, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, y_sub, out_ready,
    input  in_ready, en, x_we, x, ts, out_valid, out_data
  );

endinterface

// File: rtl/da_fir_sequencer_adder_tree.sv
// Combinational signed sum of the subfilter y words, each sign-extended to the result width.
module da_adder_tree
  import da_fir_pkg::*;
#(
  parameter int WORD_WIDTH     = 16,
  parameter int NUM_SUBFILTERS = 2,
  localparam int SUM_WIDTH     = sum_width(WORD_WIDTH, NUM_SUBFILTERS)
) (
  input  logic [NUM_SUBFILTERS*WORD_WIDTH-1:0] i_words,
  output logic signed [SUM_WIDTH-1:0]          o_sum
);

  logic signed [WORD_WIDTH-1:0] w_word;

  // Both operands are signed, so each word is sign-extended before the add.
  always_comb begin
    o_sum  = '0;
    w_word = '0;
    for (int i = 0; i < NUM_SUBFILTERS; i++) begin
      w_word = i_words[i*WORD_WIDTH +: WORD_WIDTH];
      o_sum  = o_sum + w_word;
    end
  end

endmodule

// File: rtl/da_fir_sequencer.sv
// Sequencer for the bit-serial DA FIR: loads a sample, runs WORD_WIDTH shift cycles, and
// registers the summed subfilter outputs on the sign-bit cycle.
module da_fir_sequencer
  import da_fir_pkg::*;
#(
  parameter int WORD_WIDTH     = 16,
  parameter int NUM_SUBFILTERS = 2
) (
  input logic                clk,
  input logic                rst,
  da_fir_sequencer_if.master bus
);

  localparam int SUM_WIDTH = sum_width(WORD_WIDTH, NUM_SUBFILTERS);
  localparam int CNT_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(WORD_WIDTH - 1);

  seq_state_t                  r_state;
  seq_state_t                  w_nextState;
  logic [CNT_WIDTH-1:0]        r_bitCnt;
  logic [CNT_WIDTH-1:0]        w_nextBitCnt;
  logic                        r_en;
  logic                        r_xWe;
  logic                        r_ts;
  logic                        w_en;
  logic                        w_xWe;
  logic                        w_ts;
  logic [WORD_WIDTH-1:0]       r_x;
  logic                        r_outValid;
  logic signed [SUM_WIDTH-1:0] r_outData;
  logic signed [SUM_WIDTH-1:0] w_sum;
  logic                        w_inReady;
  logic                        w_accept;

  assign w_inReady = (r_state == IDLE) && (!r_outValid || bus.out_ready);
  assign w_accept  = w_inReady && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_bitCnt <= '0;
      r_en     <= 1'b0;
      r_xWe    <= 1'b0;
      r_ts     <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_bitCnt <= w_nextBitCnt;
      r_en     <= w_en;
      r_xWe    <= w_xWe;
      r_ts     <= w_ts;
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_nextBitCnt = r_bitCnt;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = LOAD;
      end
      LOAD: begin
        w_nextState  = SHIFT;
        w_nextBitCnt = '0;
      end
      SHIFT: begin
        if (r_bitCnt == LAST_BIT) begin
          w_nextState  = IDLE;
          w_nextBitCnt = '0;
        end else begin
          w_nextBitCnt = r_bitCnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        w_nextState  = IDLE;
        w_nextBitCnt = '0;
      end
    endcase
  end

  // Strobes are registered, so they are decoded from the upcoming state.
  always_comb begin
    w_en  = (w_nextState == SHIFT);
    w_xWe = (w_nextState == LOAD);
    w_ts  = (w_nextState == SHIFT) && (w_nextBitCnt == LAST_BIT);
  end

  da_adder_tree #(
    .WORD_WIDTH    (WORD_WIDTH),
    .NUM_SUBFILTERS(NUM_SUBFILTERS)
  ) u_adderTree (
    .i_words(bus.y_sub),
    .o_sum  (w_sum)
  );

  // A reload on the ts cycle takes priority over the consumer clearing the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else begin
      if (w_accept) r_x <= bus.in_data;
      if (r_ts) begin
        r_outData  <= w_sum;
        r_outValid <= 1'b1;
      end else if (r_outValid && bus.out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.en        = r_en;
  assign bus.x_we      = r_xWe;
  assign bus.ts        = r_ts;
  assign bus.x         = r_x;
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;

endmodule
